// File: rtl/fc_rx_align_pkg.sv
// Shared Fibre Channel receive types: alignment FSM states, K28.5 comma value,
// and one-hot helpers for per-lane comma detect vectors (up to 8 lanes).
package fc;

  typedef enum logic [1:0] {ALIGN_LOS, ALIGN_ACQ, ALIGN_SYNC} align_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic int onehot_idx8(input logic [7:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fc_rx_align_if.sv
// PHY-side receive bus plus aligned big-endian output stream of fc_rx_align.
// No backpressure: one word per clock in each direction.
interface fc_rx_align_if #(
  parameter int LANES = 4
);
  localparam int OW = $clog2(LANES);

  logic [8*LANES-1:0] in_data;
  logic [LANES-1:0]   in_datak;
  logic [LANES-1:0]   in_patterndetect;
  logic [LANES-1:0]   in_syncstatus;
  logic [LANES-1:0]   in_errdetect;
  logic [LANES-1:0]   in_disperr;

  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_datak;
  logic               out_valid;
  logic               aligned;
  logic [OW-1:0]      offset;
  logic [15:0]        realign_count;
  logic [31:0]        code_err_count;

  modport master (
    output in_data, in_datak, in_patterndetect, in_syncstatus, in_errdetect, in_disperr,
    input  out_data, out_datak, out_valid, aligned, offset, realign_count, code_err_count
  );

  modport slave (
    input  in_data, in_datak, in_patterndetect, in_syncstatus, in_errdetect, in_disperr,
    output out_data, out_datak, out_valid, aligned, offset, realign_count, code_err_count
  );

endinterface

// File: rtl/fc_rx_align_rotate.sv
// Combinational lane rotate: result lane i takes lane k+i of the {cur, prev}
// concatenation, so k = 0 passes prev through unchanged.
module fc_byte_rotate #(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic [LANES*W-1:0]       i_prev,
  input  logic [LANES*W-1:0]       i_cur,
  input  logic [$clog2(LANES)-1:0] i_k,
  output logic [LANES*W-1:0]       o_dat
);

  logic [2*LANES*W-1:0] w_cat;

  assign w_cat = {i_cur, i_prev};

  always_comb begin
    o_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      o_dat[i*W +: W] = w_cat[(int'(i_k) + i)*W +: W];
    end
  end

endmodule

// File: rtl/fc_rx_align.sv
// Fibre Channel receive word aligner with LOS/ACQ/SYNC hysteresis, 3-cycle latency.
// Statistics counters exist only when FC_RX_ALIGN_STATS_EN is defined.
module fc_rx_align
  import fc::*;
#(
  parameter int LANES      = 4,
  parameter int ACQ_COUNT  = 3,
  parameter int LOSS_COUNT = 4,
  parameter int GOOD_RUN   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fc_rx_align_if.slave rx
);

  localparam int OW = $clog2(LANES);

  logic [8*LANES-1:0] r_in_dat;
  logic [LANES-1:0]   r_in_k, r_in_pd, r_in_ss, r_in_ed, r_in_de;
  logic               r_in_vld;

  align_state_t       r_state, w_state_nxt;
  logic [OW-1:0]      r_cand, w_cand_nxt, r_offset, w_off_nxt, w_o;
  logic [3:0]         r_acq_cnt, w_acq_nxt, r_err_cnt, w_err_nxt;
  logic [7:0]         r_run_cnt, w_run_nxt;
  logic               w_comma, w_err, w_enter, w_vld;

  logic [8*LANES-1:0] w_rot_dat, r_aln_dat, w_swp_dat, r_out_dat;
  logic [LANES-1:0]   w_rot_k, r_aln_k, w_swp_k, r_out_k;
  logic               r_aln_vld, r_out_vld;

  assign w_err   = r_in_vld && ((|r_in_ed) || (|r_in_de) || !(&r_in_ss));
  assign w_comma = r_in_vld && (&r_in_ss) && is_onehot8(8'(r_in_pd));
  assign w_o     = OW'(onehot_idx8(8'(r_in_pd)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ALIGN_LOS;
      r_cand    <= '0;
      r_offset  <= '0;
      r_acq_cnt <= '0;
      r_err_cnt <= '0;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_offset  <= w_off_nxt;
      r_acq_cnt <= w_acq_nxt;
      r_err_cnt <= w_err_nxt;
      r_run_cnt <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_off_nxt   = r_offset;
    w_acq_nxt   = r_acq_cnt;
    w_err_nxt   = r_err_cnt;
    w_run_nxt   = r_run_cnt;
    w_enter     = 1'b0;
    if (r_in_vld) begin
      unique case (r_state)
        ALIGN_LOS: begin
          if (w_comma) begin
            w_cand_nxt  = w_o;
            w_acq_nxt   = 4'd1;
            w_state_nxt = ALIGN_ACQ;
            w_enter     = (ACQ_COUNT == 1);
          end
        end
        ALIGN_ACQ: begin
          if (w_err) begin
            w_state_nxt = ALIGN_LOS;
          end else if (w_comma) begin
            if (w_o == r_cand) begin
              w_acq_nxt = r_acq_cnt + 4'd1;
              w_enter   = (int'(r_acq_cnt) + 1 >= ACQ_COUNT);
            end else begin
              w_cand_nxt = w_o;
              w_acq_nxt  = 4'd1;
            end
          end
        end
        ALIGN_SYNC: begin
          // A comma at a foreign offset is as bad as a code violation once locked.
          if (w_err || (w_comma && (w_o != r_offset))) begin
            w_run_nxt = '0;
            if (int'(r_err_cnt) + 1 >= LOSS_COUNT) begin
              w_state_nxt = ALIGN_LOS;
              w_err_nxt   = '0;
            end else begin
              w_err_nxt = r_err_cnt + 4'd1;
            end
          end else if (int'(r_run_cnt) + 1 >= GOOD_RUN) begin
            w_run_nxt = '0;
            if (r_err_cnt != '0) w_err_nxt = r_err_cnt - 4'd1;
          end else begin
            w_run_nxt = r_run_cnt + 8'd1;
          end
        end
        default: w_state_nxt = ALIGN_LOS;
      endcase
    end
    if (w_enter) begin
      w_state_nxt = ALIGN_SYNC;
      w_off_nxt   = w_o;
      w_err_nxt   = '0;
      w_run_nxt   = '0;
    end
  end

  // Valid spans both the word that enters SYNC and the word that leaves it.
  assign w_vld = r_in_vld && ((r_state == ALIGN_SYNC) || (w_state_nxt == ALIGN_SYNC));

  fc_byte_rotate #(.LANES(LANES), .W(8)) u_rot_dat (
    .i_prev (r_in_dat),
    .i_cur  (rx.in_data),
    .i_k    (w_off_nxt),
    .o_dat  (w_rot_dat)
  );

  fc_byte_rotate #(.LANES(LANES), .W(1)) u_rot_k (
    .i_prev (r_in_k),
    .i_cur  (rx.in_datak),
    .i_k    (w_off_nxt),
    .o_dat  (w_rot_k)
  );

  always_comb begin
    w_swp_dat = '0;
    w_swp_k   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_swp_dat[8*(LANES-1-i) +: 8] = r_aln_dat[8*i +: 8];
      w_swp_k[LANES-1-i]            = r_aln_k[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_dat  <= '0;
      r_in_k    <= '0;
      r_in_pd   <= '0;
      r_in_ss   <= '0;
      r_in_ed   <= '0;
      r_in_de   <= '0;
      r_in_vld  <= 1'b0;
      r_aln_dat <= '0;
      r_aln_k   <= '0;
      r_aln_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_k   <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_in_dat  <= rx.in_data;
      r_in_k    <= rx.in_datak;
      r_in_pd   <= rx.in_patterndetect;
      r_in_ss   <= rx.in_syncstatus;
      r_in_ed   <= rx.in_errdetect;
      r_in_de   <= rx.in_disperr;
      r_in_vld  <= 1'b1;
      r_aln_dat <= w_rot_dat;
      r_aln_k   <= w_rot_k;
      r_aln_vld <= w_vld;
      r_out_dat <= w_swp_dat;
      r_out_k   <= w_swp_k;
      r_out_vld <= r_aln_vld;
    end
  end

  assign rx.out_data  = r_out_dat;
  assign rx.out_datak = r_out_k;
  assign rx.out_valid = r_out_vld;
  assign rx.aligned   = r_out_vld;
  assign rx.offset    = r_offset;

`ifdef FC_RX_ALIGN_STATS_EN
  logic [15:0] r_realign_cnt;
  logic [31:0] r_code_err_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_realign_cnt  <= '0;
      r_code_err_cnt <= '0;
    end else begin
      if (w_enter && (r_realign_cnt != '1)) r_realign_cnt <= r_realign_cnt + 16'd1;
      if (w_err && (r_code_err_cnt != '1)) r_code_err_cnt <= r_code_err_cnt + 32'd1;
    end
  end

  assign rx.realign_count  = r_realign_cnt;
  assign rx.code_err_count = r_code_err_cnt;
`else
  assign rx.realign_count  = '0;
  assign rx.code_err_count = '0;
`endif

endmodule

// File: tb/tb_fc_rx_align.sv
// Self-checking bench for fc_rx_align (LANES=4): directed lock/hysteresis/reset
// scenarios followed by random words, checked against a byte-stream model.
module tb_fc_rx_align;
  import fc::*;

  localparam int L      = 4;
  localparam int ACQ_N  = 3;
  localparam int LOSS_N = 4;
  localparam int GOOD_N = 2;
  localparam int S_LOS  = 0;
  localparam int S_ACQ  = 1;
  localparam int S_SYNC = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fc_rx_align_if #(.LANES(L)) bus ();

  fc_rx_align #(
    .LANES(L), .ACQ_COUNT(ACQ_N), .LOSS_COUNT(LOSS_N), .GOOD_RUN(GOOD_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (bus.slave)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k, pd, ss, ed, de;
  } w_t;

  w_t     words[$];
  bit     exp_vld[$];
  int     exp_off[$];
  int     checks = 0;
  int     fails  = 0;
  int     m_state, m_cand, m_acq, m_err, m_run, m_off;
  longint m_ra, m_ce;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_LOS; m_cand = 0; m_acq = 0; m_err = 0; m_run = 0; m_off = 0;
    m_ra = 0; m_ce = 0;
    words.delete(); exp_vld.delete(); exp_off.delete();
  endtask

  task automatic model_enter_sync();
    m_state = S_SYNC; m_off = m_cand; m_err = 0; m_run = 0;
    if (m_ra < 65535) m_ra++;
  endtask

  // Word-level rules: classify, then advance LOS/ACQ/SYNC bookkeeping.
  task automatic model_step(input w_t w);
    bit err, comma, was_sync;
    int o;
    err      = (w.ed != 0) || (w.de != 0) || (w.ss != 4'hF);
    comma    = (w.ss == 4'hF) && ($countones(w.pd) == 1);
    o        = 0;
    for (int i = 0; i < L; i++) if (w.pd[i]) o = i;
    was_sync = (m_state == S_SYNC);
    if (err && m_ce < 64'hFFFF_FFFF) m_ce++;
    if (m_state == S_LOS) begin
      if (comma) begin
        m_cand = o; m_acq = 1; m_state = S_ACQ;
        if (m_acq >= ACQ_N) model_enter_sync();
      end
    end else if (m_state == S_ACQ) begin
      if (err) m_state = S_LOS;
      else if (comma) begin
        if (o == m_cand) m_acq++;
        else begin m_cand = o; m_acq = 1; end
        if (m_acq >= ACQ_N) model_enter_sync();
      end
    end else begin
      if (err || (comma && o != m_off)) begin
        m_run = 0; m_err++;
        if (m_err >= LOSS_N) begin m_state = S_LOS; m_err = 0; end
      end else begin
        m_run++;
        if (m_run >= GOOD_N) begin m_run = 0; if (m_err > 0) m_err--; end
      end
    end
    exp_vld.push_back(was_sync || (m_state == S_SYNC));
    exp_off.push_back(m_off);
  endtask

  // Output word m starts at wire byte (m*L + offset) and is emitted big-endian.
  function automatic logic [35:0] exp_out(input int m);
    logic [31:0] d;
    logic [3:0]  k;
    int src;
    d = '0; k = '0;
    for (int i = 0; i < L; i++) begin
      src = exp_off[m] + i;
      if (src < L) begin
        d[8*(L-1-i) +: 8] = words[m].d[8*src +: 8];
        k[L-1-i]          = words[m].k[src];
      end else begin
        d[8*(L-1-i) +: 8] = words[m+1].d[8*(src-L) +: 8];
        k[L-1-i]          = words[m+1].k[src-L];
      end
    end
    return {k, d};
  endfunction

  function automatic w_t mk_clean();
    w_t w;
    w.d = $urandom; w.k = 4'h0; w.pd = 4'h0; w.ss = 4'hF; w.ed = 4'h0; w.de = 4'h0;
    return w;
  endfunction

  function automatic w_t mk_comma(input int o);
    w_t w;
    w = mk_clean();
    w.pd[o] = 1'b1;
    w.k[o]  = 1'b1;
    w.d[8*o +: 8] = K28_5;
    return w;
  endfunction

  function automatic w_t mk_err(input int kind);
    w_t w;
    w = mk_clean();
    case (kind)
      0:       w.ed[$urandom_range(0, 3)] = 1'b1;
      1:       w.de[$urandom_range(0, 3)] = 1'b1;
      default: w.ss[$urandom_range(0, 3)] = 1'b0;
    endcase
    return w;
  endfunction

  task automatic apply(input w_t w);
    int n, pre_off;
    longint pre_ra, pre_ce;
    logic [35:0] e;
    bus.in_data = w.d; bus.in_datak = w.k; bus.in_patterndetect = w.pd;
    bus.in_syncstatus = w.ss; bus.in_errdetect = w.ed; bus.in_disperr = w.de;
    pre_off = m_off; pre_ra = m_ra; pre_ce = m_ce;
    words.push_back(w);
    model_step(w);
    n = words.size() - 1;
    @(posedge clk); #1;
    chk("offset", 64'(bus.offset), 64'(pre_off));
`ifdef FC_RX_ALIGN_STATS_EN
    chk("realign_count", 64'(bus.realign_count), pre_ra);
    chk("code_err_count", 64'(bus.code_err_count), pre_ce);
`else
    chk("realign_count_off", 64'(bus.realign_count), 64'd0);
    chk("code_err_count_off", 64'(bus.code_err_count), 64'd0);
`endif
    if (n >= 2) begin
      e = exp_out(n - 2);
      chk("out_valid", 64'(bus.out_valid), 64'(exp_vld[n-2]));
      chk("aligned", 64'(bus.aligned), 64'(exp_vld[n-2]));
      chk("out_data", 64'(bus.out_data), 64'(e[31:0]));
      chk("out_datak", 64'(bus.out_datak), 64'(e[35:32]));
    end else begin
      chk("early_valid", 64'(bus.out_valid), 64'd0);
      chk("early_data", 64'(bus.out_data), 64'd0);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_aligned", 64'(bus.aligned), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_datak", 64'(bus.out_datak), 64'd0);
    chk("rst_offset", 64'(bus.offset), 64'd0);
    chk("rst_realign", 64'(bus.realign_count), 64'd0);
    chk("rst_code_err", 64'(bus.code_err_count), 64'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int fav, r;
    reset_n = 1'b0;
    bus.in_data = '0; bus.in_datak = '0; bus.in_patterndetect = '0;
    bus.in_syncstatus = '0; bus.in_errdetect = '0; bus.in_disperr = '0;
    model_reset();
    do_reset(3);

    // Lock at offset 0.
    repeat (3) apply(mk_clean());
    repeat (3) apply(mk_comma(0));
    repeat (2) apply(mk_clean());
    chk("lock0_valid", 64'(bus.out_valid), 64'd1);
    chk("lock0_msb", 64'(bus.out_data[31:24]), 64'(K28_5));
    chk("lock0_datak", 64'(bus.out_datak), 64'b1000);
    repeat (3) apply(mk_clean());

    // Candidate offset changes mid-acquisition.
    do_reset(1);
    repeat (2) apply(mk_comma(1));
    apply(mk_comma(3));
    repeat (2) apply(mk_clean());
    chk("acq_still_invalid", 64'(bus.out_valid), 64'd0);
    repeat (2) apply(mk_comma(3));
    repeat (2) apply(mk_clean());
    chk("acq_offset", 64'(bus.offset), 64'd3);
    chk("acq_valid", 64'(bus.out_valid), 64'd1);

    // Hysteresis: isolated errors tolerated, then a burst of disparity errors.
    for (int g = 0; g < 33; g++) begin
      apply(mk_err(0));
      apply(mk_clean());
      apply(mk_clean());
    end
    apply(mk_clean());
    repeat (4) apply(mk_err(1));
    repeat (2) apply(mk_clean());
    chk("loss_last_valid", 64'(bus.out_valid), 64'd1);
    apply(mk_clean());
    chk("loss_dropped", 64'(bus.out_valid), 64'd0);

    // Reset while locked, then a fresh acquisition.
    repeat (3) apply(mk_comma(2));
    repeat (3) apply(mk_clean());
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    do_reset(1);
    repeat (2) apply(mk_comma(2));
    repeat (2) apply(mk_clean());
    chk("reacq_not_yet", 64'(bus.out_valid), 64'd0);
    apply(mk_clean());
    apply(mk_comma(2));
    repeat (2) apply(mk_clean());
    chk("reacq_valid", 64'(bus.out_valid), 64'd1);
    chk("reacq_offset", 64'(bus.offset), 64'd2);

    // Random traffic around a drifting favourite offset.
    fav = $urandom_range(0, L-1);
    for (int i = 0; i < 900; i++) begin
      w_t w;
      r = $urandom_range(0, 99);
      if (r < 2) fav = $urandom_range(0, L-1);
      if (r < 30) begin
        w = mk_comma(($urandom_range(0, 9) < 7) ? fav : $urandom_range(0, L-1));
      end else if (r < 44) begin
        w = mk_err($urandom_range(0, 2));
      end else begin
        w = mk_clean();
        w.k = 4'($urandom);
        if (r > 95) w.pd = 4'b0101;
      end
      apply(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
